// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: assembles a big-endian byte stream into 32-bit instruction
// words, writes them sequentially into a small instruction store, and holds
// the CPU idle until a complete program image has been loaded.
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  output logic              err,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] OneW   = (ADDR_W+1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         partial_q, partial_d;
  logic [7:0]          checksum_q, checksum_d;
  logic                err_q, err_d;

  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic                count_legal;
  logic [ADDR_W:0]     words_next;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // A start request is legal only for a word count between 1 and the store depth.
  assign count_legal = (word_count != '0) && (word_count <= DepthW);
  assign words_next  = words_q + OneW;

  // Next-state, datapath and store-write decode for the loader.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    words_d    = words_q;
    wr_addr_d  = wr_addr_q;
    byte_idx_d = byte_idx_q;
    partial_d  = partial_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wdata  = {partial_q, in_byte};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (count_legal) begin
            state_d    = S_LOAD;
            count_d    = word_count;
            words_d    = '0;
            wr_addr_d  = '0;
            byte_idx_d = 2'd0;
            partial_d  = '0;
            checksum_d = 8'h00;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          checksum_d = checksum_q ^ in_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: partial_d[23:16] = in_byte;
            2'd1: partial_d[15:8]  = in_byte;
            2'd2: partial_d[7:0]   = in_byte;
            default: begin
              mem_we    = 1'b1;
              wr_addr_d = wr_addr_q + 1'b1;
              words_d   = words_next;
              if (words_next == count_q) begin
                state_d = S_DONE;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and datapath registers; the store itself is deliberately not reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      words_q    <= '0;
      wr_addr_q  <= '0;
      byte_idx_q <= 2'd0;
      partial_q  <= '0;
      checksum_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      words_q    <= words_d;
      wr_addr_q  <= wr_addr_d;
      byte_idx_q <= byte_idx_d;
      partial_q  <= partial_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  // Instruction store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr_q] <= mem_wdata;
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign cpu_run  = (state_q == S_DONE);
  assign err      = err_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader: directed plus randomized checks of the instruction loader
// against a byte-queue reference model of the load protocol.
module tb_imem_loader;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              cpu_run;
  logic              err;
  logic [7:0]        checksum;

  int testCount = 0;
  int failCount = 0;

  // Reference model: accepted bytes of the current load kept in a queue.
  logic [31:0] mMem [DEPTH];
  bit          mKnown [DEPTH];
  logic [7:0]  mBytes [$];
  bit          mLoading;
  bit          mDone;
  bit          mErr;
  int          mTarget;
  logic [7:0]  mSum;

  logic [7:0]  prog [8];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .word_count(word_count),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .cpu_run   (cpu_run),
    .err       (err),
    .checksum  (checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mLoading = 1'b0;
    mDone    = 1'b0;
    mErr     = 1'b0;
    mSum     = 8'h00;
    mBytes.delete();
  endtask

  // Applies the load rules to one rising edge given the inputs seen there.
  task automatic modelEdge(input bit s, input int wc, input bit v, input logic [7:0] b);
    int n;
    int idx;
    if (mLoading) begin
      if (v) begin
        mBytes.push_back(b);
        mSum = mSum ^ b;
        n = mBytes.size();
        if (n % 4 == 0) begin
          idx = n / 4 - 1;
          mMem[idx]   = {mBytes[4*idx], mBytes[4*idx+1], mBytes[4*idx+2], mBytes[4*idx+3]};
          mKnown[idx] = 1'b1;
          if (n == 4 * mTarget) begin
            mLoading = 1'b0;
            mDone    = 1'b1;
          end
        end
      end
    end else if (s) begin
      if (wc >= 1 && wc <= DEPTH) begin
        mLoading = 1'b1;
        mDone    = 1'b0;
        mErr     = 1'b0;
        mTarget  = wc;
        mSum     = 8'h00;
        mBytes.delete();
      end else begin
        mErr = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge, update the model on the rising edge.
  task automatic applyStimulus(input bit s, input int wc, input bit v, input logic [7:0] b);
    @(negedge clk);
    start      = s;
    word_count = (ADDR_W+1)'(wc);
    in_valid   = v;
    in_byte    = v ? b : 8'($urandom);
    @(posedge clk);
    modelEdge(s, wc, v, b);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(mLoading));
    check({tag, "_busy"},     32'(busy),     32'(mLoading));
    check({tag, "_done"},     32'(done),     32'(mDone));
    check({tag, "_cpu_run"},  32'(cpu_run),  32'(mDone));
    check({tag, "_err"},      32'(err),      32'(mErr));
    check({tag, "_checksum"}, 32'(checksum), 32'(mSum));
  endtask

  task automatic checkMem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      if (mKnown[i]) begin
        rd_addr = ADDR_W'(i);
        #1;
        check($sformatf("%s_mem%0d", tag, i), rd_data, mMem[i]);
      end
    end
  endtask

  task automatic readAt(input string tag, input int a, input logic [31:0] exp);
    rd_addr = ADDR_W'(a);
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    int wc;
    int r;
    int budget;

    prog = '{8'h00, 8'h62, 8'h20, 8'h20, 8'h8C, 8'h45, 8'h0B, 8'hB8};
    for (int i = 0; i < DEPTH; i++) begin
      mKnown[i] = 1'b0;
      mMem[i]   = '0;
    end
    reset      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    in_byte    = 8'h00;
    in_valid   = 1'b0;
    rd_addr    = '0;
    modelReset();
    #12;
    checkOutput("reset");
    reset = 1'b1;

    // Two-word load, back-to-back bytes.
    applyStimulus(1'b1, 2, 1'b0, 8'h00);
    checkOutput("t1_start");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 0, 1'b1, prog[i]);
      checkOutput("t1_byte");
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_sum", 32'(checksum), 32'h18);
    readAt("t1_rd1", 1, 32'h8C450BB8);
    readAt("t1_rd0", 0, 32'h00622020);
    checkMem("t1");

    // Same stream with idle cycles carrying garbage bytes.
    applyStimulus(1'b1, 2, 1'b0, 8'h00);
    checkOutput("t2_start");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 0, 1'b0, 8'h00);
      checkOutput("t2_gap");
      applyStimulus(1'b0, 0, 1'b1, prog[i]);
      checkOutput("t2_byte");
    end
    check("t2_sum", 32'(checksum), 32'h18);
    checkMem("t2");

    // Illegal word counts, then a legal one clears err.
    applyStimulus(1'b1, 0, 1'b0, 8'h00);
    checkOutput("t3_zero");
    check("t3_err0", 32'(err), 32'd1);
    applyStimulus(1'b1, 33, 1'b0, 8'h00);
    checkOutput("t3_33");
    check("t3_busy33", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1, 1'b0, 8'h00);
    checkOutput("t3_legal");
    check("t3_errclr", 32'(err), 32'd0);
    applyStimulus(1'b0, 0, 1'b1, 8'h11);
    applyStimulus(1'b0, 0, 1'b1, 8'h22);
    applyStimulus(1'b0, 0, 1'b1, 8'h33);
    applyStimulus(1'b0, 0, 1'b1, 8'h44);
    checkOutput("t3_end");
    checkMem("t3");

    // Reset after five bytes of a two-word load.
    applyStimulus(1'b1, 2, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 0, 1'b1, prog[i]);
    end
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("t4_reset");
    readAt("t4_keep0", 0, 32'h00622020);
    checkMem("t4_mid");
    reset = 1'b1;
    applyStimulus(1'b1, 2, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 0, 1'b1, prog[i]);
      checkOutput("t4_byte");
    end
    checkMem("t4");

    // Full-depth load of incrementing bytes.
    applyStimulus(1'b1, DEPTH, 1'b0, 8'h00);
    for (int i = 0; i < 4 * DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b1, 8'(i));
      checkOutput("t5_byte");
    end
    readAt("t5_rd31", 31, 32'h7C7D7E7F);
    check("t5_sum", 32'(checksum), 32'h00);
    applyStimulus(1'b0, 0, 1'b1, 8'hFF);
    checkOutput("t5_extra");
    check("t5_ready", 32'(in_ready), 32'd0);
    check("t5_sumkeep", 32'(checksum), 32'h00);
    checkMem("t5");

    // Reload one word from DONE; read-during-write on address 0.
    applyStimulus(1'b1, 1, 1'b0, 8'h00);
    checkOutput("t6_start");
    check("t6_cpu_run", 32'(cpu_run), 32'd0);
    applyStimulus(1'b0, 0, 1'b1, 8'hAB);
    applyStimulus(1'b0, 0, 1'b1, 8'hCD);
    applyStimulus(1'b0, 0, 1'b1, 8'hAB);
    readAt("t6_old", 0, 32'h00010203);
    applyStimulus(1'b0, 0, 1'b1, 8'hCD);
    checkOutput("t6_end");
    readAt("t6_new", 0, 32'hABCDABCD);
    check("t6_sum", 32'(checksum), 32'h00);
    checkMem("t6");

    // Randomized loads, illegal starts, stray starts and occasional resets.
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) wc = 0;
      else if (r == 1) wc = $urandom_range(33, 63);
      else wc = $urandom_range(1, 6);
      applyStimulus(1'b1, wc, 1'b0, 8'h00);
      checkOutput("rnd_start");
      budget = 0;
      while (mLoading && budget < 200) begin
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 63),
                      $urandom_range(0, 3) != 0, 8'($urandom));
        checkOutput("rnd_cycle");
        budget++;
        if (mLoading && $urandom_range(0, 99) == 0) begin
          reset = 1'b0;
          #1;
          modelReset();
          checkOutput("rnd_reset");
          reset = 1'b1;
        end
      end
      check("rnd_finished", 32'(busy), 32'd0);
      checkMem("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the processor's instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes the words sequentially into a 32-entry instruction store and exposes a combinational read port indexed by the PC.
- Holds the CPU idle (cpu_run low) until a complete program image has been loaded.

Parameters:
- ADDR_W, 5, word address width.
- DEPTH, 32, number of instruction words (2**ADDR_W).
- DATA_W, 32, instruction word width (fixed at 4 bytes).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled in IDLE or DONE.
- word_count  input  ADDR_W+1  number of words to load (legal 1..DEPTH); sampled with start.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- rd_addr  input  ADDR_W  fetch address from the PC.
- rd_data  output  DATA_W  instruction at rd_addr (combinational).
- busy  output  1  load in progress.
- done  output  1  image complete.
- cpu_run  output  1  CPU may execute; equals done.
- err  output  1  last start had an illegal word_count.
- checksum  output  8  XOR of all bytes accepted since the last accepted start.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - in_ready, busy, done, cpu_run and err go to 0; checksum goes to 0.
  - Byte counter, word address and partial-word register are cleared.
  - Instruction store contents are NOT cleared: they persist across reset and are undefined at power-up.
- States: IDLE, LOAD, DONE.
- IDLE or DONE, start=1, word_count in 1..DEPTH:
  - Next state LOAD.
  - Latch word_count; wr_addr and byte index go to 0; checksum goes to 0.
  - err, done and cpu_run go to 0.
- IDLE or DONE, start=1, word_count = 0 or > DEPTH:
  - err goes to 1; state is unchanged (DONE keeps done/cpu_run).
  - err stays 1 until the next legal start or reset.
- LOAD:
  - in_ready=1, busy=1.
  - A byte is accepted on a rising edge with in_valid&&in_ready; cycles with in_valid=0 have no effect.
  - Byte order is big-endian: byte index 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - On the edge accepting byte index 3, the full word is written to mem[wr_addr] on that same edge and wr_addr increments.
  - Every accepted byte updates checksum ^= in_byte in the same edge.
- Last word written (words written == latched count):
  - Next state DONE on that same edge.
  - From the following cycle: busy=0, in_ready=0, done=1, cpu_run=1.
- start in LOAD is ignored.
- DONE:
  - in_ready=0; bytes presented are ignored and do not affect checksum.
  - A legal start begins a reload.
- Full-depth load (word_count=DEPTH): wr_addr wraps to 0 after the final write; it is never used again before the next start.
- Read port:
  - rd_data = mem[rd_addr] combinationally, in every state.
  - Write and read to the same address: old data is seen before the edge, new data after.
- Reset mid-LOAD:
  - Words already written remain in the store.
  - The partial word is discarded.
  - cpu_run stays 0 until a complete load.

Test Plan:
- Load 2 words, bytes 00 62 20 20 8C 45 0B B8 back-to-back -> mem[0]=0x00622020, mem[1]=0x8C450BB8; done=cpu_run=1 one cycle after the 8th byte; checksum=0x18; rd_addr=1 gives 0x8C450BB8.
- Same stream with in_valid deasserted on alternate cycles and garbage in_byte while invalid -> identical mem contents and checksum=0x18.
- start with word_count=0, then with word_count=33 -> err=1 each time, busy=0, in_ready=0. A following start with word_count=1 clears err.
- Reset asserted after 5 bytes of a 2-word load -> IDLE, all flags 0, mem[0]=0x00622020 retained, mem[1] unchanged; a subsequent full load succeeds.
- word_count=32, 128 incrementing bytes 00..7F -> mem[31]=0x7C7D7E7F, done=1, checksum=0x00; an extra byte offered in DONE is not accepted (in_ready=0, checksum unchanged).
- From DONE, start with word_count=1 and bytes AB CD AB CD -> done/cpu_run drop during LOAD; mem[0]=0xABCDABCD; other entries keep their previous values; checksum=0x00.
